// File: rtl/coax_pkg.sv
// Shared definitions for the coax receive path: FSM states, error codes, word geometry.
package coax_pkg;

  localparam int DATA_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_SYNC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_PARITY   = 3'd1;
  localparam logic [2:0] ERR_EMPTY    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;
  localparam logic [2:0] ERR_LENGTH   = 3'd5;

endpackage

// File: rtl/coax_rx_word_assembler.sv
// Shifts data bits MSB-first into a word and keeps running parity; one bit per shift, no backpressure.
module coax_rx_word_assembler
  import coax_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 bit_value,
  output logic [DATA_BITS-1:0] word,
  output logic                 full,
  output logic                 parity_ok
);

  logic [3:0] bit_index;
  logic       parity_acc;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word       <= '0;
      bit_index  <= '0;
      parity_acc <= 1'b0;
    end else if (shift && (bit_index != 4'(DATA_BITS))) begin
      word       <= {word[DATA_BITS-2:0], bit_value};
      bit_index  <= bit_index + 4'd1;
      parity_acc <= parity_acc ^ bit_value;
    end
  end

  // full also rises on the shift that completes the word, so the FSM can leave DATA on that bit
  assign full      = (bit_index == 4'(DATA_BITS)) ||
                     (shift && (bit_index == 4'(DATA_BITS - 1)));
  assign parity_ok = ((parity_acc ^ bit_value) == PARITY_ODD);

endmodule

// File: rtl/coax_rx_sequencer.sv
// Frames recovered coax bits into words, flags parity/empty/timeout/overflow/length faults.
// All outputs registered, one clock after the triggering strobe; a full FIFO aborts the message.
module coax_rx_sequencer
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int TIMEOUT_CLOCKS = (CLOCKS_PER_BIT * 5) / 2,
  parameter int MAX_WORDS      = 1024,
  parameter bit PARITY_ODD     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 ss_strobe,
  input  logic                 bit_strobe,
  input  logic                 bit_value,
  input  logic                 fifo_full,
  output logic                 ss_enable,
  output logic                 bit_enable,
  output logic                 active,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_strobe,
  output logic                 eom_strobe,
  output logic                 error_strobe,
  output logic [2:0]           error_code
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [WCW-1:0] WORD_LIMIT = WCW'(MAX_WORDS);
  localparam logic [TCW-1:0] TMO_LIMIT  = TCW'(TIMEOUT_CLOCKS);

  state_t               state, state_nxt;
  logic [WCW-1:0]       word_count;
  logic [TCW-1:0]       tmo_count;
  logic                 tmo_hit;
  logic [DATA_BITS-1:0] asm_word;
  logic                 asm_full, asm_parity_ok, asm_clear, asm_shift;
  logic                 data_strobe_nxt, eom_nxt;
  logic [2:0]           err_nxt;

  assign tmo_hit   = (tmo_count == TMO_LIMIT);
  assign asm_clear = !enable || ((state != ST_DATA) && (state != ST_PARITY));
  assign asm_shift = enable && bit_strobe && (state == ST_DATA);

  coax_rx_word_assembler #(.PARITY_ODD(PARITY_ODD)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .bit_value (bit_value),
    .word      (asm_word),
    .full      (asm_full),
    .parity_ok (asm_parity_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ss_strobe) state_nxt = ST_FIRST;
      ST_FIRST:  if (bit_strobe) state_nxt = bit_value ? ST_DATA : ST_IDLE;
      ST_SYNC:   if (bit_strobe) state_nxt = bit_value ? ST_DATA : ST_IDLE;
      ST_DATA:   if (bit_strobe && asm_full) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_strobe)
                   state_nxt = (asm_parity_ok && !fifo_full && (word_count != WORD_LIMIT))
                               ? ST_SYNC : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // a bit arriving on the limit cycle wins over the timeout
    if ((state != ST_IDLE) && !bit_strobe && tmo_hit) state_nxt = ST_IDLE;
    if (!enable) state_nxt = ST_IDLE;
  end

  always_comb begin
    data_strobe_nxt = 1'b0;
    eom_nxt         = 1'b0;
    err_nxt         = ERR_NONE;
    if (bit_strobe) begin
      case (state)
        ST_FIRST:  if (!bit_value) err_nxt = ERR_EMPTY;
        ST_SYNC:   if (!bit_value) eom_nxt = 1'b1;
        ST_PARITY: begin
          if (!asm_parity_ok)             err_nxt = ERR_PARITY;
          else if (fifo_full)             err_nxt = ERR_OVERFLOW;
          else if (word_count == WORD_LIMIT) err_nxt = ERR_LENGTH;
          else                            data_strobe_nxt = 1'b1;
        end
        default: ;
      endcase
    end else if ((state != ST_IDLE) && tmo_hit) begin
      err_nxt = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      ss_enable    <= 1'b0;
      bit_enable   <= 1'b0;
      active       <= 1'b0;
      data         <= '0;
      data_strobe  <= 1'b0;
      eom_strobe   <= 1'b0;
      error_strobe <= 1'b0;
      error_code   <= ERR_NONE;
      word_count   <= '0;
      tmo_count    <= '0;
    end else begin
      ss_enable    <= (state_nxt == ST_IDLE);
      // the first sync bit also comes from bit recovery, so FIRST keeps it enabled
      bit_enable   <= (state_nxt != ST_IDLE);
      active       <= (state_nxt != ST_IDLE);
      data_strobe  <= data_strobe_nxt;
      eom_strobe   <= eom_nxt;
      error_strobe <= (err_nxt != ERR_NONE);
      error_code   <= err_nxt;
      if (data_strobe_nxt) data <= asm_word;

      if (state == ST_IDLE)     word_count <= '0;
      else if (data_strobe_nxt) word_count <= word_count + 1'b1;

      if (bit_strobe || (state == ST_IDLE)) tmo_count <= '0;
      else if (!tmo_hit)                    tmo_count <= tmo_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_coax_rx_sequencer.sv
// Directed bench for coax_rx_sequencer with an output-event scoreboard per instance.
module tb_coax_rx_sequencer;
  import coax_pkg::*;

  typedef struct packed {
    logic [1:0] kind;  // 1 data, 2 eom, 3 error
    logic [9:0] dat;
    logic [2:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic reset, en1, en2, ss_strobe, bit_strobe, bit_value, fifo_full;

  logic       a_ss_en, a_bit_en, a_active, a_dstb, a_eom, a_err;
  logic [9:0] a_data;
  logic [2:0] a_code;
  logic       b_ss_en, b_bit_en, b_active, b_dstb, b_eom, b_err;
  logic [9:0] b_data;
  logic [2:0] b_code;

  int tests  = 0;
  int failed = 0;
  ev_t q_a[$];
  ev_t q_b[$];

  always #5 clk = ~clk;

  coax_rx_sequencer dut (
    .clk(clk), .reset(reset), .enable(en1), .ss_strobe(ss_strobe),
    .bit_strobe(bit_strobe), .bit_value(bit_value), .fifo_full(fifo_full),
    .ss_enable(a_ss_en), .bit_enable(a_bit_en), .active(a_active), .data(a_data),
    .data_strobe(a_dstb), .eom_strobe(a_eom), .error_strobe(a_err), .error_code(a_code)
  );

  coax_rx_sequencer #(.MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .ss_strobe(ss_strobe),
    .bit_strobe(bit_strobe), .bit_value(bit_value), .fifo_full(fifo_full),
    .ss_enable(b_ss_en), .bit_enable(b_bit_en), .active(b_active), .data(b_data),
    .data_strobe(b_dstb), .eom_strobe(b_eom), .error_strobe(b_err), .error_code(b_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] kind, input logic [9:0] d, input logic [2:0] code);
    ev_t e;
    e.kind = kind; e.dat = d; e.code = code;
    return e;
  endfunction

  function automatic ev_t observe(input logic ds, input logic eo, input logic [9:0] d,
                                  input logic [2:0] code);
    ev_t e;
    e.kind = ds ? 2'd1 : (eo ? 2'd2 : 2'd3);
    e.dat  = ds ? d : 10'd0;
    e.code = code;
    return e;
  endfunction

  always @(negedge clk) begin
    if (a_dstb || a_eom || a_err) begin
      check("a_one_strobe", 32'(a_dstb) + 32'(a_eom) + 32'(a_err), 32'd1);
      if (q_a.size() == 0) check("a_unexpected_event", 32'(observe(a_dstb, a_eom, a_data, a_code)), 32'd0);
      else check("a_event", 32'(observe(a_dstb, a_eom, a_data, a_code)), 32'(q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (b_dstb || b_eom || b_err) begin
      check("b_one_strobe", 32'(b_dstb) + 32'(b_eom) + 32'(b_err), 32'd1);
      if (q_b.size() == 0) check("b_unexpected_event", 32'(observe(b_dstb, b_eom, b_data, b_code)), 32'd0);
      else check("b_event", 32'(observe(b_dstb, b_eom, b_data, b_code)), 32'(q_b.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg();
    ss_strobe = 1'b1; tick(); ss_strobe = 1'b0; tick();
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_strobe = 1'b1; bit_value = b; tick();
    bit_strobe = 1'b0; bit_value = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [9:0] w, input logic par, input int gap);
    send_bit(1'b1, gap);
    for (int i = 9; i >= 0; i--) send_bit(w[i], gap);
    send_bit(par, gap);
  endtask

  initial begin
    logic [9:0] words [3];
    reset = 1'b1; en1 = 1'b1; en2 = 1'b0;
    ss_strobe = 1'b0; bit_strobe = 1'b0; bit_value = 1'b0; fifo_full = 1'b0;
    repeat (3) tick();
    check("reset_ss_enable", 32'(a_ss_en), 32'd0);
    check("reset_active", 32'(a_active), 32'd0);
    check("reset_data", 32'(a_data), 32'd0);
    check("reset_error_code", 32'(a_code), 32'd0);
    reset = 1'b0; tick();
    check("idle_ss_enable", 32'(a_ss_en), 32'd1);

    // single word then end of message
    start_msg();
    check("first_active", 32'(a_active), 32'd1);
    check("first_ss_enable", 32'(a_ss_en), 32'd0);
    q_a.push_back(mk(2'd1, 10'h2A5, ERR_NONE));
    send_word(10'h2A5, 1'b1, 3);
    check("word_data_held", 32'(a_data), 32'h2A5);
    q_a.push_back(mk(2'd2, 10'h000, ERR_NONE));
    send_bit(1'b0, 3);
    check("eom_active", 32'(a_active), 32'd0);

    // three words back to back
    words[0] = 10'h000; words[1] = 10'h3FF; words[2] = 10'h155;
    start_msg();
    for (int i = 0; i < 3; i++) begin
      q_a.push_back(mk(2'd1, words[i], ERR_NONE));
      send_word(words[i], ^words[i], 2);
    end
    q_a.push_back(mk(2'd2, 10'h000, ERR_NONE));
    send_bit(1'b0, 3);
    check("multi_drained", 32'(q_a.size()), 32'd0);

    // wrong parity
    start_msg();
    q_a.push_back(mk(2'd3, 10'h000, ERR_PARITY));
    send_bit(1'b1, 2);
    for (int i = 9; i >= 0; i--) send_bit(i == 0, 2);
    send_bit(1'b0, 0);
    check("parity_err_strobe", 32'(a_err), 32'd1);
    check("parity_no_data", 32'(a_dstb), 32'd0);
    check("parity_ss_enable", 32'(a_ss_en), 32'd1);
    check("parity_active", 32'(a_active), 32'd0);
    tick();

    // empty message
    start_msg();
    q_a.push_back(mk(2'd3, 10'h000, ERR_EMPTY));
    send_bit(1'b0, 3);

    // timeout mid-DATA
    start_msg();
    send_bit(1'b1, 2);
    send_bit(1'b1, 2); send_bit(1'b0, 2);
    q_a.push_back(mk(2'd3, 10'h000, ERR_TIMEOUT));
    send_bit(1'b1, 0);
    repeat (20) tick();
    check("timeout_not_early", 32'(a_err), 32'd0);
    tick();
    check("timeout_strobe", 32'(a_err), 32'd1);
    check("timeout_code", 32'(a_code), 32'(ERR_TIMEOUT));
    repeat (2) tick();

    // FIFO full at parity
    start_msg();
    fifo_full = 1'b1;
    q_a.push_back(mk(2'd3, 10'h000, ERR_OVERFLOW));
    send_word(10'h0F0, 1'b0, 2);
    fifo_full = 1'b0;
    check("overflow_active", 32'(a_active), 32'd0);

    // every bit arrives exactly on the timeout limit cycle
    start_msg();
    q_a.push_back(mk(2'd1, 10'h19C, ERR_NONE));
    send_word(10'h19C, ^10'h19C, 20);
    q_a.push_back(mk(2'd2, 10'h000, ERR_NONE));
    send_bit(1'b0, 3);
    check("limit_drained", 32'(q_a.size()), 32'd0);

    // enable dropped mid-DATA
    start_msg();
    send_bit(1'b1, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    en1 = 1'b0; tick();
    check("abort_active", 32'(a_active), 32'd0);
    check("abort_bit_enable", 32'(a_bit_en), 32'd0);
    check("abort_ss_enable", 32'(a_ss_en), 32'd0);
    en1 = 1'b1; tick();
    check("reenable_ss_enable", 32'(a_ss_en), 32'd1);
    repeat (30) tick();

    // length limit on the MAX_WORDS=2 instance
    en1 = 1'b0; en2 = 1'b1; tick();
    start_msg();
    words[0] = 10'h111; words[1] = 10'h222; words[2] = 10'h333;
    q_b.push_back(mk(2'd1, words[0], ERR_NONE));
    q_b.push_back(mk(2'd1, words[1], ERR_NONE));
    q_b.push_back(mk(2'd3, 10'h000, ERR_LENGTH));
    for (int i = 0; i < 3; i++) send_word(words[i], ^words[i], 2);
    check("length_active", 32'(b_active), 32'd0);
    check("length_data_held", 32'(b_data), 32'h222);
    repeat (3) tick();

    check("final_drain_a", 32'(q_a.size()), 32'd0);
    check("final_drain_b", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
